// File: rtl/camera_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : camera_controller_if
//  Brief    : Target-in / camera-out signal bundle between the physics side
//             (master) and the camera controller (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface camera_controller_if #(
    parameter int WORLD_BITS = 32
);
    logic signed [WORLD_BITS-1:0] target_x_in;
    logic signed [WORLD_BITS-1:0] target_y_in;
    logic                         target_valid_in;
    logic                         new_frame_in;
    logic                         snap_in;
    logic signed [WORLD_BITS-1:0] camera_x_out;
    logic signed [WORLD_BITS-1:0] camera_y_out;
    logic                         camera_update_out;
    logic                         busy_out;

    modport master (
        output target_x_in, target_y_in, target_valid_in, new_frame_in, snap_in,
        input  camera_x_out, camera_y_out, camera_update_out, busy_out
    );

    modport slave (
        input  target_x_in, target_y_in, target_valid_in, new_frame_in, snap_in,
        output camera_x_out, camera_y_out, camera_update_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/camera_controller.sv
`default_nettype none
// ============================================================================
//  Module   : camera_controller
//  Brief    : Smoothed, step-limited, world-clamped camera tracking that
//             commits a new camera position at most once per frame.
//  Revision : 1.0  initial release
// ============================================================================
module camera_controller #(
    parameter int                           WORLD_BITS   = 32,
    parameter int                           SMOOTH_SHIFT = 2,
    parameter int                           MAX_STEP     = 64,
    parameter logic signed [WORLD_BITS-1:0] X_MIN        = -1048576,
    parameter logic signed [WORLD_BITS-1:0] X_MAX        = 1048575,
    parameter logic signed [WORLD_BITS-1:0] Y_MIN        = -1048576,
    parameter logic signed [WORLD_BITS-1:0] Y_MAX        = 1048575,
    parameter logic signed [WORLD_BITS-1:0] INIT_X       = 0,
    parameter logic signed [WORLD_BITS-1:0] INIT_Y       = 0
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    camera_controller_if.slave cam_if
);

    typedef logic signed [WORLD_BITS-1:0] cam_t;
    typedef logic signed [WORLD_BITS:0]   wide_t;

    localparam wide_t c_max_step = wide_t'(MAX_STEP);
    localparam wide_t c_min_step = -c_max_step;
    localparam wide_t c_x_min    = wide_t'(X_MIN);
    localparam wide_t c_x_max    = wide_t'(X_MAX);
    localparam wide_t c_y_min    = wide_t'(Y_MIN);
    localparam wide_t c_y_max    = wide_t'(Y_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRACK  = 3'd1,
        S_CALC   = 3'd2,
        S_LIMIT  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_busy;

    cam_t   r_tgt_x, r_tgt_y;
    cam_t   r_work_x, r_work_y;
    logic   r_work_snap;
    logic   r_have_target;
    logic   r_snap_pending;
    wide_t  r_dx, r_dy;
    wide_t  r_step_x, r_step_y;
    cam_t   r_next_x, r_next_y;
    cam_t   r_cam_x, r_cam_y;
    logic   r_update;

    wide_t  w_dx, w_dy;
    wide_t  w_lim_x, w_lim_y;
    wide_t  w_pos_x, w_pos_y;
    logic   w_snap_set;

    // Arithmetic shift floors; a small positive error still nudges by one.
    function automatic wide_t f_smooth(input wide_t d);
        wide_t s;
        s = d >>> SMOOTH_SHIFT;
        if (!d[WORLD_BITS] && (d != '0) && (s == '0))
            s = wide_t'(1);
        return s;
    endfunction

    function automatic wide_t f_clamp(input wide_t v, input wide_t lo, input wide_t hi);
        if (v < lo)
            return lo;
        if (v > hi)
            return hi;
        return v;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE:   if (r_have_target) w_state_next = S_TRACK;
            S_TRACK:  if (cam_if.new_frame_in) w_state_next = S_CALC;
            S_CALC:   begin w_state_next = S_LIMIT;  w_busy = 1'b1; end
            S_LIMIT:  begin w_state_next = S_COMMIT; w_busy = 1'b1; end
            S_COMMIT: begin w_state_next = S_TRACK;  w_busy = 1'b1; end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_dx    = wide_t'(r_work_x) - wide_t'(r_cam_x);
        w_dy    = wide_t'(r_work_y) - wide_t'(r_cam_y);
        w_lim_x = r_work_snap ? r_dx : f_clamp(r_step_x, c_min_step, c_max_step);
        w_lim_y = r_work_snap ? r_dy : f_clamp(r_step_y, c_min_step, c_max_step);
        w_pos_x = f_clamp(wide_t'(r_cam_x) + w_lim_x, c_x_min, c_x_max);
        w_pos_y = f_clamp(wide_t'(r_cam_y) + w_lim_y, c_y_min, c_y_max);
        w_snap_set = cam_if.snap_in | (cam_if.target_valid_in & ~r_have_target);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tgt_x        <= INIT_X;
            r_tgt_y        <= INIT_Y;
            r_work_x       <= INIT_X;
            r_work_y       <= INIT_Y;
            r_work_snap    <= 1'b0;
            r_have_target  <= 1'b0;
            r_snap_pending <= 1'b0;
            r_dx           <= '0;
            r_dy           <= '0;
            r_step_x       <= '0;
            r_step_y       <= '0;
            r_next_x       <= INIT_X;
            r_next_y       <= INIT_Y;
            r_cam_x        <= INIT_X;
            r_cam_y        <= INIT_Y;
            r_update       <= 1'b0;
        end else begin
            r_update <= (r_state == S_COMMIT);

            if (cam_if.target_valid_in) begin
                r_tgt_x       <= cam_if.target_x_in;
                r_tgt_y       <= cam_if.target_y_in;
                r_have_target <= 1'b1;
            end

            // A set in the commit cycle wins so it carries into the next update.
            r_snap_pending <= w_snap_set | (r_snap_pending & (r_state != S_COMMIT));

            case (r_state)
                S_TRACK: begin
                    if (cam_if.new_frame_in) begin
                        r_work_x    <= cam_if.target_valid_in ? cam_if.target_x_in : r_tgt_x;
                        r_work_y    <= cam_if.target_valid_in ? cam_if.target_y_in : r_tgt_y;
                        r_work_snap <= r_snap_pending | cam_if.snap_in;
                    end
                end
                S_CALC: begin
                    r_dx     <= w_dx;
                    r_dy     <= w_dy;
                    r_step_x <= f_smooth(w_dx);
                    r_step_y <= f_smooth(w_dy);
                end
                S_LIMIT: begin
                    r_next_x <= cam_t'(w_pos_x);
                    r_next_y <= cam_t'(w_pos_y);
                end
                S_COMMIT: begin
                    r_cam_x <= r_next_x;
                    r_cam_y <= r_next_y;
                end
                default: ;
            endcase
        end
    end

    assign cam_if.camera_x_out      = r_cam_x;
    assign cam_if.camera_y_out      = r_cam_y;
    assign cam_if.camera_update_out = r_update;
    assign cam_if.busy_out          = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_camera_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_camera_controller
//  Brief    : Directed stimulus with a queue of expected camera commits that a
//             free-running monitor checks against every update pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_camera_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        longint x;
        longint y;
        int     cyc;
    } exp_t;

    exp_t sb[$];

    camera_controller_if #(.WORLD_BITS(32)) bus ();

    camera_controller #(
        .X_MAX (1000)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .cam_if (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every cycle: an update pulse must appear exactly when a commit is due.
    always @(negedge clk) begin : mon
        logic exp_upd;
        exp_t e;
        exp_upd = (sb.size() != 0) && (sb[0].cyc == cyc);
        check("update_pulse", bus.camera_update_out, exp_upd);
        if (bus.camera_update_out === 1'b1 && sb.size() != 0) begin
            e = sb.pop_front();
            check("cam_x", bus.camera_x_out, e.x);
            check("cam_y", bus.camera_y_out, e.y);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_target(input logic signed [31:0] x, input logic signed [31:0] y);
        bus.target_x_in     = x;
        bus.target_y_in     = y;
        bus.target_valid_in = 1'b1;
        tick(1);
        bus.target_valid_in = 1'b0;
    endtask

    task automatic frame(input logic signed [31:0] ex, input logic signed [31:0] ey,
                         input bit snap_commit);
        sb.push_back('{ex, ey, cyc + 4});
        bus.new_frame_in = 1'b1;
        tick(1);
        bus.new_frame_in = 1'b0;
        check("busy_calc", bus.busy_out, 1);
        tick(2);
        if (snap_commit) bus.snap_in = 1'b1;
        tick(1);
        bus.snap_in = 1'b0;
        tick(1);
        check("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic init_at(input logic signed [31:0] x, input logic signed [31:0] y);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        set_target(x, y);
        tick(1);
        frame(x, y, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.target_x_in     = '0;
        bus.target_y_in     = '0;
        bus.target_valid_in = 1'b0;
        bus.new_frame_in    = 1'b0;
        bus.snap_in         = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_cam_x", bus.camera_x_out, 0);
        check("rst_cam_y", bus.camera_y_out, 0);
        check("rst_busy", bus.busy_out, 0);

        // No target yet: frames are ignored.
        repeat (2) begin
            bus.new_frame_in = 1'b1;
            tick(1);
            bus.new_frame_in = 1'b0;
            tick(2);
        end
        check("idle_cam_x", bus.camera_x_out, 0);
        check("idle_busy", bus.busy_out, 0);

        // First target snaps.
        set_target(100, -3);
        tick(1);
        frame(100, -3, 1'b0);

        // Smoothing, floor of negative, minimum +1 step.
        init_at(0, 0);
        set_target(100, -3);
        frame(25, -1, 1'b0);
        init_at(0, 0);
        set_target(2, 0);
        frame(1, 0, 1'b0);
        init_at(0, 0);
        set_target(-2, -5);
        frame(-1, -2, 1'b0);

        // Target arriving in the frame cycle is the one used.
        init_at(0, 0);
        bus.target_x_in     = 40;
        bus.target_y_in     = 8;
        bus.target_valid_in = 1'b1;
        frame(10, 2, 1'b0);
        bus.target_valid_in = 1'b0;

        // Step limit over ten frames, then an explicit snap.
        init_at(0, 0);
        set_target(1000, -1000);
        for (int i = 1; i <= 10; i++)
            frame(64 * i, -64 * i, 1'b0);
        bus.snap_in = 1'b1;
        tick(1);
        bus.snap_in = 1'b0;
        frame(1000, -1000, 1'b0);

        // Snap requested during commit applies to the following update.
        init_at(0, 0);
        set_target(1000, 0);
        frame(64, 0, 1'b1);
        frame(1000, 0, 1'b0);

        // World clamp at X_MAX, including on a snap.
        init_at(990, 0);
        set_target(5000, 0);
        frame(1000, 0, 1'b0);
        frame(1000, 0, 1'b0);
        set_target(5000, 7);
        bus.snap_in = 1'b1;
        tick(1);
        bus.snap_in = 1'b0;
        frame(1000, 7, 1'b0);

        // Second new_frame while in CALC is dropped.
        init_at(0, 0);
        set_target(100, 100);
        frame(25, 25, 1'b0);
        sb.push_back('{43, 43, cyc + 4});
        bus.new_frame_in = 1'b1;
        tick(2);
        bus.new_frame_in = 1'b0;
        tick(3);
        check("drop_drain", sb.size(), 0);
        sb.delete();
        tick(5);
        check("drop_cam_x", bus.camera_x_out, 43);

        // Reset while in LIMIT aborts the update.
        bus.new_frame_in = 1'b1;
        tick(1);
        bus.new_frame_in = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_cam_x", bus.camera_x_out, 0);
        check("abort_cam_y", bus.camera_y_out, 0);
        check("abort_busy", bus.busy_out, 0);
        tick(6);
        bus.new_frame_in = 1'b1;
        tick(1);
        bus.new_frame_in = 1'b0;
        check("abort_idle_busy", bus.busy_out, 0);
        tick(5);
        check("abort_idle_cam_x", bus.camera_x_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
